nvram_bk_ctrl: RTL and testbench
================================

NVRAM_BK_CTRL -- requirements
Module: nvram_bk_ctrl

Interface
REQ-001 SHALL have parameter SECTORS, default 64, meaning the number of 512-byte sectors per backup image (power of two, 2..256).
REQ-002 SHALL have parameter TIMEOUT, default 24'd12000000, meaning the clk_sys cycles allowed between request assertion and sd_ack rise.
REQ-003 SHALL have port clk_sys  input  1  system clock; all logic on the rising edge.
REQ-004 SHALL have port RESET_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port bk_ena  input  1  writable save image mounted.
REQ-006 SHALL have port load_req  input  1  OSD load command (level).
REQ-007 SHALL have port save_req  input  1  OSD save command (level).
REQ-008 SHALL have port autosave_en  input  1  autosave option enabled.
REQ-009 SHALL have port osd_open  input  1  OSD currently displayed.
REQ-010 SHALL have port nvram_we  input  1  game write strobe to backup RAM.
REQ-011 SHALL have port dl_done  input  1  one-cycle pulse at end of cartridge download.
REQ-012 SHALL have port img_nz  input  1  mounted image size non-zero.
REQ-013 SHALL have port sd_ack  input  1  host sector transfer in progress.
REQ-014 SHALL have port sd_lba  output  32  current sector; upper bits zero.
REQ-015 SHALL have ports sd_rd and sd_wr  output  1 each  sector read/write requests.
REQ-016 SHALL have port bk_loading  output  1  load in progress; holds the system in reset.
REQ-017 SHALL have ports bk_busy, bk_pending and bk_err  output  1 each  transfer active, unsaved writes exist, last transfer timed out.

Function
REQ-018 SHALL implement states IDLE, REQ, ACK and NEXT.
REQ-019 Triggers in IDLE SHALL be:
- rising edge of load_req&bk_ena -> load;
- rising edge of save_req&bk_ena -> save;
- rising edge of (bk_pending&osd_open&autosave_en&bk_ena) -> save;
- dl_done&img_nz&bk_ena -> load.
REQ-020 Simultaneous load and save triggers SHALL start a load; triggers outside IDLE SHALL be discarded, not queued.
REQ-021 On trigger the block SHALL set sd_lba=0, bk_busy=1, bk_loading=is_load, sd_rd=is_load, sd_wr=~is_load, and enter REQ in the next cycle.
REQ-022 In REQ, the cycle sd_ack rises SHALL clear sd_rd/sd_wr and enter ACK.
REQ-023 In ACK, the cycle sd_ack falls SHALL enter NEXT.
REQ-024 In NEXT, if sd_lba==SECTORS-1 the block SHALL clear bk_busy and bk_loading and enter IDLE.
REQ-025 In NEXT otherwise the block SHALL increment sd_lba, reassert the same request and enter REQ, giving one idle cycle between ack fall and the next request.
REQ-026 A timer SHALL count cycles in REQ; at TIMEOUT it SHALL clear sd_rd, sd_wr, bk_busy and bk_loading, set bk_err, and enter IDLE.
REQ-027 bk_err SHALL clear on the next accepted trigger.
REQ-028 bk_pending SHALL set when bk_ena&~osd_open&nvram_we.
REQ-029 bk_pending SHALL clear on entry to REQ of sector 0 of a save; a set in the same cycle SHALL win over the clear.
REQ-030 bk_ena falling mid-transfer SHALL NOT abort the transfer.
REQ-031 sd_ack high while in IDLE SHALL be ignored.

Reset
REQ-032 RESET_n low SHALL asynchronously force IDLE, with sd_lba=0 and sd_rd, sd_wr, bk_loading, bk_busy, bk_pending, bk_err and the timer all 0.
REQ-033 Edge-detect registers SHALL reset to 1 so a level request held high through reset does not trigger.

Structure
REQ-034 A shared package bk_pkg SHALL hold the state enum bk_state_t and the constant SECTOR_BYTES=512.
REQ-035 One sub-module, bk_edge (rising-edge detector), SHALL be instantiated per trigger source.

Verification
REQ-036 Save: bk_ena=1, pulse save_req, host acks each request 3 cycles later for 4 cycles -> 64 sd_wr pulses, sd_lba 0..63, bk_busy falls one cycle after the 64th ack fall.
REQ-037 Post-download load: dl_done with img_nz=1 -> bk_loading high throughout 64 sd_rd sectors, low after sector 63.
REQ-038 Autosave: nvram_we with osd_open=0, then osd_open=1 and autosave_en=1 -> bk_pending=1 and exactly one save starts; bk_pending clears when sector 0 enters REQ.
REQ-039 Timeout: TIMEOUT=100, no sd_ack -> sd_wr drops at cycle 100 and bk_err=1; the next save_req clears bk_err.
REQ-040 Collision: load_req and save_req rise in the same cycle -> load only.
REQ-041 Collision: save_req during a load -> ignored.
REQ-042 Reset: RESET_n low at sector 10 -> all outputs 0 immediately, and no trigger occurs after release while save_req stays high.

Source files
------------

// File: rtl/bk_pkg.sv
// Shared types and constants for the NVRAM backup sequencer.
package bk_pkg;

  localparam int SECTOR_BYTES = 512;

  typedef enum logic [1:0] {
    BK_IDLE = 2'd0,
    BK_REQ  = 2'd1,
    BK_ACK  = 2'd2,
    BK_NEXT = 2'd3
  } bk_state_t;

endpackage

// File: rtl/bk_edge.sv
// Rising-edge detector for a level trigger. The history flop resets high so a
// level already asserted when reset releases is not seen as a new edge.
module bk_edge (
  input  logic clk_sys,
  input  logic RESET_n,
  input  logic sig,
  output logic rise
);

  logic prev_q;

  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) prev_q <= 1'b1;
    else          prev_q <= sig;
  end

  assign rise = sig & ~prev_q;

endmodule

// File: rtl/nvram_bk_ctrl.sv
// Sequences whole-image backup RAM loads/saves as per-sector host requests.
//   state   | meaning
//   IDLE    | waiting for a load/save trigger
//   REQ     | sd_rd/sd_wr raised, waiting for sd_ack rise (timed)
//   ACK     | host transferring, waiting for sd_ack fall
//   NEXT    | one gap cycle; advance sector or finish
module nvram_bk_ctrl
  import bk_pkg::*;
#(
  parameter int          SECTORS = 64,
  parameter logic [23:0] TIMEOUT = 24'd12000000
) (
  input  logic        clk_sys,
  input  logic        RESET_n,
  input  logic        bk_ena,
  input  logic        load_req,
  input  logic        save_req,
  input  logic        autosave_en,
  input  logic        osd_open,
  input  logic        nvram_we,
  input  logic        dl_done,
  input  logic        img_nz,
  input  logic        sd_ack,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  output logic        bk_loading,
  output logic        bk_busy,
  output logic        bk_pending,
  output logic        bk_err
);

  localparam int               LBA_W    = (SECTORS > 1) ? $clog2(SECTORS) : 1;
  localparam logic [LBA_W-1:0] LBA_LAST = LBA_W'(SECTORS - 1);

  bk_state_t        state_q, state_d;
  logic [LBA_W-1:0] lba_q, lba_d;
  logic [23:0]      tmr_q, tmr_d;
  logic             rd_q, rd_d, wr_q, wr_d;
  logic             load_q, load_d, busy_q, busy_d;
  logic             pend_q, pend_d, err_q, err_d;
  logic             ack_q;
  logic             load_rise, save_rise, auto_rise;
  logic             load_trig, save_trig, ack_rise, ack_fall;

  bk_edge u_edge_load (
    .clk_sys(clk_sys), .RESET_n(RESET_n), .sig(load_req & bk_ena), .rise(load_rise)
  );
  bk_edge u_edge_save (
    .clk_sys(clk_sys), .RESET_n(RESET_n), .sig(save_req & bk_ena), .rise(save_rise)
  );
  bk_edge u_edge_auto (
    .clk_sys(clk_sys), .RESET_n(RESET_n),
    .sig(pend_q & osd_open & autosave_en & bk_ena), .rise(auto_rise)
  );

  assign load_trig = load_rise | (dl_done & img_nz & bk_ena);
  assign save_trig = save_rise | auto_rise;
  assign ack_rise  = sd_ack & ~ack_q;
  assign ack_fall  = ~sd_ack & ack_q;

  always_comb begin
    state_d = state_q;
    lba_d   = lba_q;
    tmr_d   = tmr_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    load_d  = load_q;
    busy_d  = busy_q;
    pend_d  = pend_q;
    err_d   = err_q;
    case (state_q)
      BK_IDLE: begin
        if (load_trig | save_trig) begin
          state_d = BK_REQ;
          lba_d   = '0;
          tmr_d   = TIMEOUT - 24'd1;
          busy_d  = 1'b1;
          load_d  = load_trig;
          rd_d    = load_trig;
          wr_d    = ~load_trig;
          err_d   = 1'b0;
          if (!load_trig) pend_d = 1'b0;
        end
      end
      BK_REQ: begin
        if (ack_rise) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = BK_ACK;
        end else if (tmr_q == '0) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          busy_d  = 1'b0;
          load_d  = 1'b0;
          err_d   = 1'b1;
          state_d = BK_IDLE;
        end else begin
          tmr_d = tmr_q - 24'd1;
        end
      end
      BK_ACK: begin
        if (ack_fall) state_d = BK_NEXT;
      end
      BK_NEXT: begin
        if (lba_q == LBA_LAST) begin
          busy_d  = 1'b0;
          load_d  = 1'b0;
          state_d = BK_IDLE;
        end else begin
          lba_d   = lba_q + LBA_W'(1);
          rd_d    = load_q;
          wr_d    = ~load_q;
          tmr_d   = TIMEOUT - 24'd1;
          state_d = BK_REQ;
        end
      end
      default: state_d = BK_IDLE;
    endcase
    // a game write landing in the same cycle as the save start stays pending
    if (bk_ena & ~osd_open & nvram_we) pend_d = 1'b1;
  end

  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q <= BK_IDLE;
      lba_q   <= '0;
      tmr_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
      ack_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      lba_q   <= lba_d;
      tmr_q   <= tmr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      load_q  <= load_d;
      busy_q  <= busy_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      ack_q   <= sd_ack;
    end
  end

  assign sd_lba     = 32'(lba_q);
  assign sd_rd      = rd_q;
  assign sd_wr      = wr_q;
  assign bk_loading = load_q;
  assign bk_busy    = busy_q;
  assign bk_pending = pend_q;
  assign bk_err     = err_q;

endmodule

// File: tb/tb_nvram_bk_ctrl.sv
// Bench for nvram_bk_ctrl: a behavioural SD host logs every sector request and
// the main sequence compares the log against the expected whole-image transfer.
module tb_nvram_bk_ctrl;

  localparam int SECTORS = 64;
  localparam int LOGSZ   = 4096;

  logic        clk_sys = 1'b0;
  logic        RESET_n;
  logic        bk_ena, load_req, save_req, autosave_en, osd_open;
  logic        nvram_we, dl_done, img_nz;
  logic        sd_ack = 1'b0;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, bk_loading, bk_busy, bk_pending, bk_err;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // host model state
  bit host_on;
  int ack_dly, ack_len;
  int h_phase = 0;
  int h_cnt   = 0;
  int log_n   = 0;
  int log_lba [LOGSZ];
  bit log_wr  [LOGSZ];
  bit log_ld  [LOGSZ];
  int drop_cyc = 0;
  int h_err    = 0;
  int gap_err  = 0;

  // snapshot taken before each trigger
  int xb, xhe, xge;

  nvram_bk_ctrl #(.SECTORS(SECTORS), .TIMEOUT(24'd100)) dut (
    .clk_sys(clk_sys), .RESET_n(RESET_n), .bk_ena(bk_ena), .load_req(load_req),
    .save_req(save_req), .autosave_en(autosave_en), .osd_open(osd_open),
    .nvram_we(nvram_we), .dl_done(dl_done), .img_nz(img_nz), .sd_ack(sd_ack),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .bk_loading(bk_loading),
    .bk_busy(bk_busy), .bk_pending(bk_pending), .bk_err(bk_err)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  // host: ack each request ack_dly cycles after seeing it, hold ack_len cycles
  always @(negedge clk_sys) begin
    if (!RESET_n) begin
      sd_ack  = 1'b0;
      h_phase = 0;
    end else if (host_on) begin
      case (h_phase)
        0: if (sd_rd || sd_wr) begin
          if (log_n < LOGSZ) begin
            log_lba[log_n] = int'(sd_lba);
            log_wr[log_n]  = sd_wr;
            log_ld[log_n]  = bk_loading;
          end
          log_n++;
          if ((sd_rd && sd_wr) || !bk_busy) h_err++;
          if (sd_lba != 0 && cyc - drop_cyc != 2) gap_err++;
          h_cnt   = ack_dly;
          h_phase = 1;
        end
        1: begin
          if (!(sd_rd || sd_wr)) h_err++;
          h_cnt--;
          if (h_cnt == 0) begin
            sd_ack  = 1'b1;
            h_cnt   = ack_len;
            h_phase = 2;
          end
        end
        default: begin
          if (sd_rd || sd_wr) h_err++;
          h_cnt--;
          if (h_cnt == 0) begin
            sd_ack   = 1'b0;
            drop_cyc = cyc;
            h_phase  = 0;
          end
        end
      endcase
    end
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic snap();
    xb  = log_n;
    xhe = h_err;
    xge = gap_err;
  endtask

  // exp: 0 none, 1 save, 2 load; called on the negedge after the trigger cycle
  task automatic chk_start(input string tag, input int exp);
    if (exp == 0) chk(tag, bk_busy, 0);
    else chk(tag, {bk_busy, bk_loading, sd_rd, sd_wr}, (exp == 2) ? 4'b1110 : 4'b1001);
  endtask

  task automatic run_xfer(input string tag, input bit exp_wr);
    int n;
    int bad;
    int t_fall;
    n = 0;
    while (bk_busy && n < 3000) begin
      @(negedge clk_sys);
      n++;
    end
    chk({tag, "_done"}, (n < 3000), 1);
    t_fall = cyc;
    chk({tag, "_busy_fall"}, t_fall - drop_cyc, 2);
    repeat (10) @(negedge clk_sys);
    chk({tag, "_n_sectors"}, log_n - xb, SECTORS);
    bad = 0;
    for (int i = 0; i < SECTORS; i++)
      if (log_lba[xb+i] != i || log_wr[xb+i] != exp_wr || log_ld[xb+i] != !exp_wr) bad++;
    chk({tag, "_sector_log"}, bad, 0);
    chk({tag, "_host_err"}, (h_err - xhe) + (gap_err - xge), 0);
    chk({tag, "_idle"}, {bk_busy, bk_loading, sd_rd, sd_wr}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    bit m_pend;
    int n;
    m_pend = 1'b0;
    RESET_n = 1'b0; bk_ena = 1'b1; load_req = 1'b0; save_req = 1'b1;
    autosave_en = 1'b0; osd_open = 1'b0; nvram_we = 1'b0; dl_done = 1'b0; img_nz = 1'b0;
    host_on = 1'b1; ack_dly = 3; ack_len = 4;

    // reset state, and a save_req level held across release must not trigger
    repeat (3) @(negedge clk_sys);
    chk("rst_outs", {sd_rd, sd_wr, bk_loading, bk_busy, bk_pending, bk_err}, 0);
    chk("rst_lba", sd_lba, 0);
    RESET_n = 1'b1;
    repeat (5) @(negedge clk_sys);
    chk("rst_held_req", bk_busy, 0);
    save_req = 1'b0;
    @(negedge clk_sys);

    // directed save
    snap();
    save_req = 1'b1;
    @(negedge clk_sys);
    chk_start("save_start", 1);
    save_req = 1'b0;
    run_xfer("save", 1'b1);

    // post-download load
    snap();
    img_nz = 1'b1; dl_done = 1'b1;
    @(negedge clk_sys);
    dl_done = 1'b0;
    chk_start("dl_start", 2);
    run_xfer("dl_load", 1'b0);

    // load and save rise together; another save edge mid-load is discarded
    snap();
    load_req = 1'b1; save_req = 1'b1;
    @(negedge clk_sys);
    chk_start("coll_start", 2);
    save_req = 1'b0;
    repeat (150) @(negedge clk_sys);
    save_req = 1'b1;
    run_xfer("coll_load", 1'b0);
    load_req = 1'b0; save_req = 1'b0;
    repeat (3) @(negedge clk_sys);

    // randomized triggers
    for (int it = 0; it < 8; it++) begin
      int kind;
      int exp;
      bit ena, nz, we_open;
      kind    = $urandom_range(0, 3);
      ena     = ($urandom_range(0, 3) != 0);
      nz      = 1'($urandom_range(0, 1));
      we_open = 1'($urandom_range(0, 1));
      ack_dly = $urandom_range(1, 4);
      ack_len = $urandom_range(1, 4);
      bk_ena = ena; osd_open = we_open; nvram_we = 1'b1;
      @(negedge clk_sys);
      nvram_we = 1'b0; osd_open = 1'b0;
      if (ena && !we_open) m_pend = 1'b1;
      chk("rnd_pend_set", bk_pending, m_pend);
      snap();
      case (kind)
        0: save_req = 1'b1;
        1: load_req = 1'b1;
        2: begin load_req = 1'b1; save_req = 1'b1; end
        default: begin img_nz = nz; dl_done = 1'b1; end
      endcase
      if (!ena) exp = 0;
      else if (kind == 0) exp = 1;
      else if (kind == 3) exp = nz ? 2 : 0;
      else exp = 2;
      @(negedge clk_sys);
      dl_done = 1'b0;
      chk_start("rnd_start", exp);
      if (exp != 0) begin
        if (exp == 1) m_pend = 1'b0;
        if ($urandom_range(0, 1) == 1) bk_ena = 1'b0;
        run_xfer("rnd", exp == 1);
      end else begin
        repeat (10) @(negedge clk_sys);
        chk("rnd_no_xfer", log_n - xb, 0);
      end
      load_req = 1'b0; save_req = 1'b0;
      repeat (3) @(negedge clk_sys);
      chk("rnd_pend_model", bk_pending, m_pend);
    end

    // timeout with a silent host, then the next save clears bk_err
    ack_dly = 3; ack_len = 4;
    bk_ena = 1'b1; host_on = 1'b0;
    @(negedge clk_sys);
    save_req = 1'b1;
    @(negedge clk_sys);
    m_pend = 1'b0;
    n = 0;
    while (sd_wr && n < 500) begin
      n++;
      @(negedge clk_sys);
    end
    chk("tmo_len", n, 100);
    chk("tmo_flags", {bk_err, bk_busy, bk_loading, sd_rd}, 4'b1000);
    save_req = 1'b0; host_on = 1'b1;
    @(negedge clk_sys);
    snap();
    save_req = 1'b1;
    @(negedge clk_sys);
    chk("tmo_err_clear", bk_err, 0);
    chk_start("tmo_restart", 1);
    save_req = 1'b0;
    run_xfer("tmo_save", 1'b1);

    // autosave on OSD open with pending writes
    osd_open = 1'b0; nvram_we = 1'b1;
    @(negedge clk_sys);
    nvram_we = 1'b0;
    chk("auto_pend_set", bk_pending, 1);
    snap();
    autosave_en = 1'b1; osd_open = 1'b1;
    @(negedge clk_sys);
    chk_start("auto_start", 1);
    chk("auto_pend_clr", bk_pending, 0);
    run_xfer("auto", 1'b1);
    repeat (20) @(negedge clk_sys);
    chk("auto_once", log_n - xb, SECTORS);
    autosave_en = 1'b0; osd_open = 1'b0;
    @(negedge clk_sys);

    // reset mid-transfer at sector 10 with save_req left high
    snap();
    save_req = 1'b1;
    @(negedge clk_sys);
    chk_start("rst_xfer_start", 1);
    n = 0;
    while (log_n - xb < 11 && n < 2000) begin
      @(negedge clk_sys);
      n++;
    end
    chk("rst_pre_lba", sd_lba, 10);
    #2 RESET_n = 1'b0;
    #1;
    chk("rst_async_outs", {sd_rd, sd_wr, bk_loading, bk_busy, bk_pending, bk_err}, 0);
    chk("rst_async_lba", sd_lba, 0);
    repeat (3) @(negedge clk_sys);
    RESET_n = 1'b1;
    xb = log_n;
    repeat (30) @(negedge clk_sys);
    chk("rst_no_retrig", (log_n - xb) + int'(bk_busy), 0);
    save_req = 1'b0;
    @(negedge clk_sys);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
